// File: rtl/jts16_obj_lbuf.sv
// Double-buffered object line buffer: the draw side fills one bank while the
// display side reads and erases the other. Define JTS16_OBJ_PRIOCMP_EN for priority-compared writes.
module jts16_obj_lbuf #(
  parameter int DW      = 12,
  parameter int AW      = 9,
  parameter int PW      = 2,
  parameter int PXL_DLY = 8,
  parameter int HSTART  = 'haa,
  parameter int FSTART  = 'hc0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          flip,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] pxl
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] HOBJ_NORM = AW'(HSTART - PXL_DLY);
  localparam logic [AW-1:0] HOBJ_FLIP = AW'((DEPTH-1) + (FSTART - (HSTART - PXL_DLY)));

  if (PW < 1 || PW > DW - 4) begin : g_bad_pw
    $error("jts16_obj_lbuf: priority field overlaps the pen bits");
  end

  logic            r_sel;
  logic            r_lhbl_l;
  logic [AW-1:0]   r_hobj;
  logic [DW-1:0]   r_pxl;
  logic [DW-1:0]   r_mem [2*DEPTH];

  logic            w_fall;
  logic            w_wbank;
  logic            w_rd_en;
  logic [AW:0]     w_rd_idx;
  logic            w_wr_en;
  logic [AW:0]     w_wr_idx;
  logic [DW-1:0]   w_wr_data;

  assign w_fall   = r_lhbl_l & ~LHBL;
  // A write on the toggle clock already belongs to the new write bank.
  assign w_wbank  = r_sel ^ w_fall;
  assign w_rd_en  = LHBL & pxl_cen & ~rst;
  assign w_rd_idx = {~r_sel, r_hobj};
  assign pxl      = r_pxl;

`ifdef JTS16_OBJ_PRIOCMP_EN
  logic            r_s1_vld;
  logic            r_s1_bank;
  logic [AW-1:0]   r_s1_addr;
  logic [DW-1:0]   r_s1_data;
  logic [DW-1:0]   r_s1_old;
  logic [AW:0]     w_s1_idx;
  logic            w_s2_keep;

  assign w_s1_idx  = {w_wbank, wr_addr};
  assign w_s2_keep = (r_s1_old[3:0] == 4'd0) ||
                     (r_s1_data[DW-1 -: PW] >= r_s1_old[DW-1 -: PW]);
  assign w_wr_en   = r_s1_vld & w_s2_keep & ~rst;
  assign w_wr_idx  = {r_s1_bank, r_s1_addr};
  assign w_wr_data = r_s1_data;

  always_ff @(posedge clk) begin
    if (rst) r_s1_vld <= 1'b0;
    else     r_s1_vld <= we && (wr_data[3:0] != 4'd0);
  end

  // Stage 1 sees the RAM before stage 2 lands, so forward a same-address write.
  always_ff @(posedge clk) begin
    r_s1_bank <= w_wbank;
    r_s1_addr <= wr_addr;
    r_s1_data <= wr_data;
    r_s1_old  <= (w_wr_en && (w_wr_idx == w_s1_idx)) ? r_s1_data : r_mem[w_s1_idx];
  end
`else
  assign w_wr_en   = we & (wr_data[3:0] != 4'd0) & ~rst;
  assign w_wr_idx  = {w_wbank, wr_addr};
  assign w_wr_data = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (w_rd_en) r_mem[w_rd_idx] <= '0;
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel    <= 1'b0;
      r_lhbl_l <= 1'b1;
      r_hobj   <= HOBJ_NORM;
      r_pxl    <= '0;
    end else begin
      r_lhbl_l <= LHBL;
      if (w_fall) r_sel <= ~r_sel;
      if (!LHBL) begin
        r_hobj <= flip ? HOBJ_FLIP : HOBJ_NORM;
        r_pxl  <= '0;
      end else if (pxl_cen) begin
        r_hobj <= flip ? r_hobj - AW'(1) : r_hobj + AW'(1);
        r_pxl  <= r_mem[w_rd_idx];
      end
    end
  end

endmodule
